// File: rtl/copro_pkg.sv
// Shared coprocessor instruction-word layout, used by the issuer and the
// coprocessor decoder.
package copro_pkg;

  localparam int unsigned INSTR_W  = 15;

  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned SIZE_LSB = 3;
  localparam int unsigned ADDR_LSB = 6;
  localparam int unsigned FLAG_BIT = 14;

  // Opcode 0 loads a matrix; 1..7 select ALU operations.
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ALU1 = 3'b001;
  localparam logic [2:0] OP_ALU7 = 3'b111;

  // Packs command fields into the coprocessor instruction word.
  function automatic logic [INSTR_W-1:0] encode(input logic       flag,
                                                input logic [7:0] addr,
                                                input logic [2:0] size,
                                                input logic [2:0] opc);
    logic [INSTR_W-1:0] word;
    word                  = '0;
    word[OPC_LSB +: 3]    = opc;
    word[SIZE_LSB +: 3]   = size;
    word[ADDR_LSB +: 8]   = addr;
    word[FLAG_BIT]        = flag;
    return word;
  endfunction

endpackage

// File: rtl/copro_cmd_fifo.sv
// Command FIFO holding pre-encoded instruction words. The caller guarantees
// no push when full and no pop when empty.
module copro_cmd_fifo
  import copro_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [INSTR_W-1:0]     wdata,
  output logic [INSTR_W-1:0]     rdata,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]    level_q, level_d;

  // Storage array; contents are meaningless while level is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  // Occupancy next-state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  assign rdata = mem[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/copro_instr_issuer.sv
// Issues buffered host commands to the coprocessor, one per fixed
// FETCH/DECODE/EXECUTE slot aligned to phase 0. Illegal size codes are
// accepted but dropped and flagged on erro.
// Optional: define COPRO_ISSUER_STATS_EN for saturating issued/rejected counters.
module copro_instr_issuer
  import copro_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SLOT_CYCLES = 3,
  parameter int unsigned MIN_SIZE    = 2,
  parameter int unsigned MAX_SIZE    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_opcode,
  input  logic [2:0]             cmd_size,
  input  logic [7:0]             cmd_addr,
  input  logic                   cmd_flag_a,
  output logic [INSTR_W-1:0]     instruction,
  output logic                   instr_valid,
  output logic                   erro,
  output logic                   retired,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef COPRO_ISSUER_STATS_EN
  ,
  output logic [15:0]            issued_count,
  output logic [15:0]            rejected_count
`endif
);

  localparam int unsigned LvlW   = $clog2(DEPTH) + 1;
  localparam int unsigned PhW    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [PhW-1:0]  PhLast = PhW'(SLOT_CYCLES - 1);
  localparam logic [LvlW-1:0] Full   = LvlW'(DEPTH);
  localparam logic [2:0]      MinSz  = 3'(MIN_SIZE);
  localparam logic [2:0]      MaxSz  = 3'(MAX_SIZE);

  logic [PhW-1:0]     phase_q, phase_d;
  logic               slot_end;
  logic               xfer, legal, push, pop;
  logic [INSTR_W-1:0] enc_word, head_word;
  logic [LvlW-1:0]    level;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_valid_q, erro_q;

  assign slot_end  = (phase_q == PhLast);
  assign cmd_ready = (level != Full);
  assign xfer      = cmd_valid && cmd_ready;
  assign legal     = (cmd_size >= MinSz) && (cmd_size <= MaxSz);
  assign push      = xfer && legal;
  assign pop       = slot_end && (level != '0);
  assign enc_word  = encode(cmd_flag_a, cmd_addr, cmd_size, cmd_opcode);

  copro_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (head_word),
    .level (level)
  );

  // Phase counter next-state: free-running 0..SLOT_CYCLES-1.
  always_comb begin
    phase_d = phase_q + PhW'(1);
    if (slot_end) phase_d = '0;
  end

  // Phase and instruction output registers; the word only moves at slot boundaries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q       <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      erro_q        <= 1'b0;
    end else begin
      phase_q <= phase_d;
      erro_q  <= xfer && !legal;
      if (slot_end) begin
        instr_valid_q <= pop;
        if (pop) instr_q <= head_word;
      end
    end
  end

  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign erro        = erro_q;
  assign retired     = instr_valid_q && slot_end;
  assign busy        = (level != '0) || instr_valid_q;
  assign fifo_level  = level;

`ifdef COPRO_ISSUER_STATS_EN
  logic [15:0] issued_q, rejected_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_q   <= '0;
      rejected_q <= '0;
    end else begin
      if (retired && (issued_q != 16'hFFFF))  issued_q   <= issued_q + 16'd1;
      if (erro_q && (rejected_q != 16'hFFFF)) rejected_q <= rejected_q + 16'd1;
    end
  end

  assign issued_count   = issued_q;
  assign rejected_count = rejected_q;
`endif

endmodule

// File: tb/tb_copro_instr_issuer.sv
// Directed bench for copro_instr_issuer with a small cycle model/scoreboard.
module tb_copro_instr_issuer;

  localparam int DEPTH = 4;
  localparam int SLOT  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode = '0;
  logic [2:0]  cmd_size = '0;
  logic [7:0]  cmd_addr = '0;
  logic        cmd_flag_a = 1'b0;
  logic [14:0] instruction;
  logic        instr_valid, erro, retired, busy;
  logic [2:0]  fifo_level;
`ifdef COPRO_ISSUER_STATS_EN
  logic [15:0] issued_count, rejected_count;
`endif

  always #5 clk = ~clk;

  copro_instr_issuer #(
    .DEPTH       (DEPTH),
    .SLOT_CYCLES (SLOT),
    .MIN_SIZE    (2),
    .MAX_SIZE    (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_size    (cmd_size),
    .cmd_addr    (cmd_addr),
    .cmd_flag_a  (cmd_flag_a),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .erro        (erro),
    .retired     (retired),
    .busy        (busy),
    .fifo_level  (fifo_level)
`ifdef COPRO_ISSUER_STATS_EN
    ,
    .issued_count   (issued_count),
    .rejected_count (rejected_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_phase = 0;
  int          m_lvl = 0;
  logic [14:0] m_q[$];
  logic [14:0] m_instr = '0;
  logic        m_valid = 1'b0;
  logic        m_erro = 1'b0;
  logic        last_xfer = 1'b0;
  logic        saw_full = 1'b0;
  int          dut_ret = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("fifo_level", 32'(fifo_level), 32'(m_lvl));
    check_eq("instr_valid", 32'(instr_valid), 32'(m_valid));
    check_eq("instruction", 32'(instruction), 32'(m_instr));
    check_eq("retired", 32'(retired), 32'(m_valid && (m_phase == SLOT - 1)));
    check_eq("erro", 32'(erro), 32'(m_erro));
    check_eq("cmd_ready", 32'(cmd_ready), 32'(m_lvl != DEPTH));
    check_eq("busy", 32'(busy), 32'((m_lvl != 0) || m_valid));
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [7:0] a, input logic f);
    cmd_valid  = v;
    cmd_opcode = op;
    cmd_size   = sz;
    cmd_addr   = a;
    cmd_flag_a = f;
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick();
    logic        xfer, lg;
    logic [14:0] w;
    xfer = cmd_valid && (m_lvl != DEPTH);
    lg   = (cmd_size >= 3'd2) && (cmd_size <= 3'd5);
    w    = {cmd_flag_a, cmd_addr, cmd_size, cmd_opcode};
    @(posedge clk);
    #1;
    if (m_phase == SLOT - 1) begin
      if (m_q.size() != 0) begin
        m_instr = m_q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (xfer && lg) m_q.push_back(w);
    m_lvl     = m_q.size();
    m_erro    = xfer && !lg;
    m_phase   = (m_phase + 1) % SLOT;
    last_xfer = xfer;
    if (m_lvl == DEPTH) saw_full = 1'b1;
    if (retired) dut_ret++;
    check_model();
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 8'd0, 1'b0);
    #1;
    m_q.delete();
    m_lvl   = 0;
    m_valid = 1'b0;
    m_instr = '0;
    m_erro  = 1'b0;
    check_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    m_phase = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (busy || m_valid); i++) tick();
    check_eq("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic align_phase0();
    for (int i = 0; i < SLOT && m_phase != 0; i++) tick();
  endtask

  initial begin
    int ret0;
    int idx;

    // Test 1: reset state and single command latency
    do_reset();
    drive(1'b0, 3'd0, 3'd0, 8'd0, 1'b0);
    tick();                                   // now phase 1
    drive(1'b1, 3'd1, 3'd3, 8'h2A, 1'b0);
    tick();                                   // phase 2
    drive(1'b0, 3'd0, 3'd0, 8'd0, 1'b0);
    check_eq("t1_level", 32'(fifo_level), 32'd1);
    tick();                                   // phase 0
    check_eq("t1_word", 32'(instruction), 32'h0A99);
    check_eq("t1_valid", 32'(instr_valid), 32'd1);
    tick();
    tick();                                   // phase 2
    check_eq("t1_retired", 32'(retired), 32'd1);
    tick();                                   // phase 0
    check_eq("t1_idle_valid", 32'(instr_valid), 32'd0);
    check_eq("t1_idle_busy", 32'(busy), 32'd0);

    // Test 2: illegal sizes are accepted, dropped and flagged
    drive(1'b1, 3'd2, 3'd6, 8'h11, 1'b0);
    tick();
    check_eq("t2_erro_a", 32'(erro), 32'd1);
    drive(1'b1, 3'd2, 3'd1, 8'h12, 1'b1);
    tick();
    check_eq("t2_erro_b", 32'(erro), 32'd1);
    drive(1'b0, 3'd0, 3'd0, 8'd0, 1'b0);
    tick();
    check_eq("t2_erro_off", 32'(erro), 32'd0);
    repeat (3) tick();
    check_eq("t2_level", 32'(fifo_level), 32'd0);

    // Test 3: six back-to-back commands through a 4-deep FIFO
    align_phase0();
    saw_full = 1'b0;
    ret0     = dut_ret;
    idx      = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      drive(1'b1, 3'(idx + 1), 3'(2 + idx % 4), 8'(8'h10 * idx + 3), idx[0]);
      tick();
      if (last_xfer) idx++;
    end
    drive(1'b0, 3'd0, 3'd0, 8'd0, 1'b0);
    check_eq("t3_pushed", 32'(idx), 32'd6);
    check_eq("t3_saw_full", 32'(saw_full), 32'd1);
    drain();
    check_eq("t3_retired", 32'(dut_ret - ret0), 32'd6);

    // Test 4: push on the slot-boundary cycle with two queued
    align_phase0();
    ret0 = dut_ret;
    drive(1'b1, 3'd3, 3'd2, 8'hA0, 1'b0);
    tick();
    drive(1'b1, 3'd4, 3'd4, 8'hB0, 1'b1);
    tick();
    check_eq("t4_pre_level", 32'(fifo_level), 32'd2);
    drive(1'b1, 3'd5, 3'd5, 8'hC0, 1'b0);
    tick();
    check_eq("t4_level", 32'(fifo_level), 32'd2);
    drive(1'b0, 3'd0, 3'd0, 8'd0, 1'b0);
    drain();
    check_eq("t4_retired", 32'(dut_ret - ret0), 32'd3);

    // Test 5: reset in phase 1 of a valid slot with three queued
    align_phase0();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'(k), 3'd3, 8'(8'h40 + k), 1'b0);
      tick();
    end
    check_eq("t5_pre_valid", 32'(instr_valid), 32'd1);
    check_eq("t5_pre_level", 32'(fifo_level), 32'd3);
    ret0 = dut_ret;
    do_reset();
    repeat (6) tick();
    check_eq("t5_no_retire", 32'(dut_ret - ret0), 32'd0);

`ifdef COPRO_ISSUER_STATS_EN
    // Test 6: statistics counters
    check_eq("t6_issued0", 32'(issued_count), 32'd0);
    begin
      logic [2:0] sizes [7] = '{3'd3, 3'd6, 3'd2, 3'd4, 3'd0, 3'd5, 3'd3};
      idx = 0;
      for (int c = 0; c < 40 && idx < 7; c++) begin
        drive(1'b1, 3'd1, sizes[idx], 8'(idx), 1'b0);
        tick();
        if (last_xfer) idx++;
      end
    end
    drive(1'b0, 3'd0, 3'd0, 8'd0, 1'b0);
    drain();
    check_eq("t6_issued", 32'(issued_count), 32'd5);
    check_eq("t6_rejected", 32'(rejected_count), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
